// File: rtl/dac_output_stage.sv
// dac_output_stage
//   Converts signed mixer samples into offset-binary words for a unipolar DAC.
//   The three-stage pipeline does the following:
//     S1: applies the attenuation shift, clamped to IN_WIDTH-1.
//     S2: applies the soft-mute gain, which is 0..256 with 256 as unity.
//     S3: saturates to OUT_WIDTH and flips the MSB to give offset-binary.
//   A hold counter stretches the clip indicator.
//   Optional build macro DAC_DITHER_EN adds LFSR rectangular dither ahead of the
//   shift, which gives stochastic rounding instead of floor.
// Ports:
//   i_clk, i_reset       clock and synchronous active-high reset
//   i_sample             signed input sample
//   i_sample_valid       one-cycle strobe; i_sample and i_shift are captured on it
//   i_shift              right-shift amount
//   i_mute               level; 1 requests soft mute, 0 requests unmute
//   o_dac_out            offset-binary DAC word, held between updates
//   o_dac_valid          one-cycle pulse when o_dac_out updates
//   o_clip               saturation indicator with hold
//   o_muted              high while fully muted
module dac_output_stage #(
   parameter int IN_WIDTH  = 24,
   parameter int OUT_WIDTH = 16,
   parameter int RAMP_STEP = 1,
   parameter int CLIP_HOLD = 4096
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic signed [IN_WIDTH-1:0]  i_sample,
   input  logic                        i_sample_valid,
   input  logic        [4:0]           i_shift,
   input  logic                        i_mute,
   output logic        [OUT_WIDTH-1:0] o_dac_out,
   output logic                        o_dac_valid,
   output logic                        o_clip,
   output logic                        o_muted
);

   localparam int S1_W = IN_WIDTH + 1;
   localparam int PR_W = IN_WIDTH + 10;
   localparam int CW   = $clog2(CLIP_HOLD + 1);
   localparam logic [4:0]  SHIFT_MAX = 5'(IN_WIDTH - 1);
   localparam logic [8:0]  STEP      = 9'(RAMP_STEP);
   localparam logic [8:0]  UNITY     = 9'd256;
   localparam logic signed [PR_W-1:0] SAT_MAX = (PR_W'(1) <<< (OUT_WIDTH - 1)) - PR_W'(1);
   localparam logic signed [PR_W-1:0] SAT_MIN = -(PR_W'(1) <<< (OUT_WIDTH - 1));
   localparam logic [OUT_WIDTH-1:0]   MIDSCALE = {1'b1, {(OUT_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {UNMUTED, RAMP_DOWN, MUTED, RAMP_UP} state_t;

   function automatic logic is_clip(input logic signed [PR_W-1:0] v);
      return (v > SAT_MAX) || (v < SAT_MIN);
   endfunction

   function automatic logic signed [OUT_WIDTH-1:0] sat_out(input logic signed [PR_W-1:0] v);
      if (v > SAT_MAX) return SAT_MAX[OUT_WIDTH-1:0];
      if (v < SAT_MIN) return SAT_MIN[OUT_WIDTH-1:0];
      return OUT_WIDTH'(v);
   endfunction

   function automatic logic [8:0] gain_dn(input logic [8:0] g);
      return (g > STEP) ? (g - STEP) : 9'd0;
   endfunction

   function automatic logic [8:0] gain_up(input logic [8:0] g);
      logic [9:0] s;
      s = {1'b0, g} + {1'b0, STEP};
      return (s >= 10'd256) ? UNITY : s[8:0];
   endfunction

   state_t                     state, state_n;
   logic        [8:0]          gain, gain_n;
   logic                       vld_p1, vld_p2;
   logic signed [S1_W-1:0]     s1_p1;
   logic signed [PR_W-1:0]     p_p2;
   logic        [CW-1:0]       clip_cnt;
   logic        [4:0]          shift_c;
   logic signed [S1_W-1:0]     s1_in;
   logic signed [PR_W-1:0]     prod;
   logic signed [OUT_WIDTH-1:0] sat_p2;
   logic                       clip_p2;

   assign shift_c = (i_shift > SHIFT_MAX) ? SHIFT_MAX : i_shift;

`ifdef DAC_DITHER_EN
   logic [15:0]            lfsr;
   logic [15:0]            dmask;
   logic signed [S1_W-1:0] dith;

   // Mask of the low 'shift' bits; shifts of 16 and above saturate to all ones.
   assign dmask = 16'((17'd1 << shift_c) - 17'd1);
   assign dith  = $signed(S1_W'(lfsr & dmask));
   // The guard bit in S1_W keeps the dithered sum from wrapping.
   assign s1_in = S1_W'(i_sample) + dith;

   always_ff @(posedge i_clk) begin
      if (i_reset)
         lfsr <= 16'hACE1;
      else if (i_sample_valid)
         lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
   end
`else
   assign s1_in = S1_W'(i_sample);
`endif

   // Full-precision product: gain is zero-extended so the multiply stays signed.
   assign prod    = PR_W'(s1_p1) * $signed(PR_W'(gain));
   assign sat_p2  = sat_out(p_p2);
   assign clip_p2 = is_clip(p_p2);

   // Gain/mute FSM. Direction follows the current state; S2 always sees the
   // pre-update gain because the new value only lands at the clock edge.
   always_comb begin
      state_n = state;
      gain_n  = gain;
      unique case (state)
         UNMUTED: begin
            if (i_mute) state_n = RAMP_DOWN;
         end
         RAMP_DOWN: begin
            if (vld_p1) gain_n = gain_dn(gain);
            if (!i_mute)           state_n = RAMP_UP;
            else if (gain_n == 0)  state_n = MUTED;
         end
         MUTED: begin
            if (!i_mute) state_n = RAMP_UP;
         end
         RAMP_UP: begin
            if (vld_p1) gain_n = gain_up(gain);
            if (i_mute)                state_n = RAMP_DOWN;
            else if (gain_n == UNITY)  state_n = UNMUTED;
         end
         default: state_n = UNMUTED;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         vld_p1      <= 1'b0;
         vld_p2      <= 1'b0;
         o_dac_valid <= 1'b0;
         o_dac_out   <= MIDSCALE;
         clip_cnt    <= '0;
         state       <= UNMUTED;
         gain        <= UNITY;
      end else begin
         vld_p1      <= i_sample_valid;
         vld_p2      <= vld_p1;
         o_dac_valid <= vld_p2;
         state       <= state_n;
         gain        <= gain_n;
         if (vld_p2) begin
            o_dac_out <= {~sat_p2[OUT_WIDTH-1], sat_p2[OUT_WIDTH-2:0]};
            if (clip_p2)
               clip_cnt <= CW'(CLIP_HOLD);
            else if (clip_cnt != 0)
               clip_cnt <= clip_cnt - 1'b1;
         end
      end
   end

   // S1: shift boundary
   always_ff @(posedge i_clk) begin
      if (i_sample_valid) s1_p1 <= s1_in >>> shift_c;
   end

   // S2: gain boundary
   always_ff @(posedge i_clk) begin
      if (vld_p1) p_p2 <= prod >>> 8;
   end

   assign o_clip  = (clip_cnt != 0);
   assign o_muted = (state == MUTED);

endmodule

// File: tb/tb_dac_output_stage.sv
// Scoreboard bench for dac_output_stage in the default (no dither) build.
module tb_dac_output_stage;

   localparam int CLIP_HOLD = 4096;

   logic               clk = 1'b0;
   logic               rst;
   logic signed [23:0] sample;
   logic               sample_valid;
   logic        [4:0]  shift;
   logic               mute;
   logic        [15:0] dac_out;
   logic               dac_valid;
   logic               clip;
   logic               muted;

   dac_output_stage #(
      .IN_WIDTH (24),
      .OUT_WIDTH(16),
      .RAMP_STEP(1),
      .CLIP_HOLD(CLIP_HOLD)
   ) dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_sample      (sample),
      .i_sample_valid(sample_valid),
      .i_shift       (shift),
      .i_mute        (mute),
      .o_dac_out     (dac_out),
      .o_dac_valid   (dac_valid),
      .o_clip        (clip),
      .o_muted       (muted)
   );

   always #5 clk = ~clk;

   typedef struct {
      int dout;
      bit clip;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   vcount = 0;
   int   run_len = 0;
   int   max_run = 0;
   bit   muted_seen = 1'b0;

   // Monitor: pops one expectation per DUT output.
   always @(negedge clk) begin
      exp_t e;
      if (dac_valid) begin
         vcount++;
         run_len++;
         if (run_len > max_run) max_run = run_len;
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output: dac_out=%0d clip=%0d, none expected", dac_out, clip);
         end else begin
            e = sb.pop_front();
            if (int'(dac_out) != e.dout || clip != e.clip) begin
               n_err++;
               $display("FAIL output: dac_out=%0d clip=%0d, expected dac_out=%0d clip=%0d",
                        dac_out, clip, e.dout, e.clip);
            end
         end
      end else begin
         run_len = 0;
      end
      if (muted) muted_seen = 1'b1;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic send(input int s, input int sh, input int exp_out, input bit exp_clip);
      exp_t e;
      sample       = 24'(s);
      shift        = 5'(sh);
      sample_valid = 1'b1;
      e.dout = exp_out;
      e.clip = exp_clip;
      sb.push_back(e);
      @(posedge clk); #1;
      sample_valid = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic int min256(input int g);
      return (g > 256) ? 256 : g;
   endfunction

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0;
      rst = 1'b1; sample = '0; sample_valid = 1'b0; shift = '0; mute = 1'b0;
      tick(3);
      chk("reset_dac_out", int'(dac_out), 32768);
      chk("reset_valid", int'(dac_valid), 0);
      rst = 1'b0;
      tick(1);
      chk("post_reset_dac_out", int'(dac_out), 32768);
      chk("post_reset_clip", int'(clip), 0);
      chk("post_reset_muted", int'(muted), 0);

      // Passthrough with latency and single-pulse check
      send(4, 2, 32769, 0);
      tick(1); chk("lat_cyc1_valid", int'(dac_valid), 0);
      tick(1); chk("lat_cyc2_valid", int'(dac_valid), 1);
               chk("lat_cyc2_out", int'(dac_out), 32769);
      tick(1); chk("lat_cyc3_valid", int'(dac_valid), 0);
               chk("held_out", int'(dac_out), 32769);
      send(-4, 2, 32767, 0);
      tick(6);

      // Shift is captured per sample, back-to-back
      send(4, 2, 32769, 0);
      send(4, 0, 32772, 0);
      // Zero with full shift, negative floor, zero passthrough
      send(0, 31, 32768, 0);
      send(-1, 5, 32767, 0);
      send(0, 0, 32768, 0);
      tick(6);

      // Saturation and clip hold
      send(100000, 0, 65535, 1);
      send(-100000, 0, 0, 1);
      for (int k = 1; k <= CLIP_HOLD; k++) send(0, 0, 32768, k < CLIP_HOLD);
      tick(6);
      chk("clip_released", int'(clip), 0);

      // Shift clamp with back-to-back strobes
      max_run = 0;
      for (int k = 0; k < 8; k++) send(-8388608, 31, 32767, 0);
      tick(6);
      chk("b2b_run_length", max_run, 8);

      // Soft mute ramp down to MUTED and back up
      mute = 1'b1;
      tick(1);
      for (int k = 0; k <= 256; k++) send(4096, 0, 32768 + 16 * (256 - k), 0);
      tick(6);
      chk("muted_after_ramp", int'(muted), 1);
      mute = 1'b0;
      tick(1);
      chk("unmute_leaves_muted", int'(muted), 0);
      for (int k = 0; k <= 257; k++) send(4096, 0, 32768 + 16 * min256(k), 0);
      tick(6);

      // Ramp reversal at gain 128
      muted_seen = 1'b0;
      mute = 1'b1;
      tick(1);
      for (int k = 0; k < 128; k++) send(4096, 0, 32768 + 16 * (256 - k), 0);
      tick(6);
      mute = 1'b0;
      tick(1);
      for (int k = 0; k < 130; k++) send(4096, 0, 32768 + 16 * min256(128 + k), 0);
      tick(6);
      chk("reversal_never_muted", int'(muted_seen), 0);

      // Reset during RAMP_DOWN with three samples in flight
      mute = 1'b1;
      tick(1);
      for (int k = 0; k < 4; k++) send(4096, 0, 32768 + 16 * (256 - k), 0);
      tick(6);
      v0 = vcount;
      sample = 24'sd4096; shift = 5'd0; sample_valid = 1'b1;
      tick(1);
      tick(1);
      rst = 1'b1; mute = 1'b0;
      tick(1);
      rst = 1'b0; sample_valid = 1'b0;
      tick(8);
      chk("reset_drops_inflight", vcount - v0, 0);
      chk("reset_mid_dac_out", int'(dac_out), 32768);
      chk("reset_mid_muted", int'(muted), 0);
      send(4096, 0, 36864, 0);
      tick(6);

      chk("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dac_output_stage.md
# dac_output_stage

Parametrised sample-to-DAC conversion stage sitting between the voice mixer output and the DAC pins. It replaces the fixed bit-slice and offset with a registered pipeline that provides:

- runtime-selectable attenuation shift;
- saturation with a clip indicator;
- a click-free soft-mute gain ramp;
- conversion to offset-binary for a unipolar DAC.

It consumes one mixed sample per valid strobe and emits one DAC word per strobe.

## Interface
- IN_WIDTH, 24, signed input sample width
- OUT_WIDTH, 16, DAC word width (OUT_WIDTH <= IN_WIDTH)
- RAMP_STEP, 1, gain change per accepted sample during mute ramps (1..256)
- CLIP_HOLD, 4096, number of output samples o_clip stays high after the last clip
- i_clk  in  1  system clock; everything is synchronous to this one clock
- i_reset  in  1  synchronous, active-high reset
- i_sample  in  IN_WIDTH  signed two's-complement mixed sample
- i_sample_valid  in  1  one-cycle strobe; i_sample and i_shift are sampled on it
- i_shift  in  5  arithmetic right-shift amount; values above IN_WIDTH-1 are clamped to IN_WIDTH-1
- i_mute  in  1  level; 1 requests soft mute, 0 requests unmute
- o_dac_out  out  OUT_WIDTH  offset-binary DAC word, held between updates
- o_dac_valid  out  1  one-cycle pulse when o_dac_out updates
- o_clip  out  1  saturation indicator, with hold
- o_muted  out  1  high only in state MUTED

## Operation
- Pipeline stage S1 (on i_sample_valid): `s1 = i_sample >>> shift` (arithmetic, floor), carried at IN_WIDTH+1 bits.
- Pipeline stage S2: `p = (s1 * gain) >>> 8`.
  - gain is a 9-bit unsigned value in 0..256; 256 is exact passthrough.
  - The product is IN_WIDTH+10 bits signed; there is no intermediate truncation.
- Pipeline stage S3: saturate p to the signed OUT_WIDTH range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Invert the MSB to form offset-binary, register it into o_dac_out, and pulse o_dac_valid.
  - Set the clip flag if saturation occurred.
- Gain/mute FSM, with states UNMUTED, RAMP_DOWN, MUTED, RAMP_UP:
  - UNMUTED (gain=256): i_mute=1 moves to RAMP_DOWN.
  - RAMP_DOWN: each S2 load does gain -= RAMP_STEP, floored at 0. When gain reaches 0, move to MUTED. i_mute=0 moves to RAMP_UP from the current gain.
  - MUTED (gain=0): i_mute=0 moves to RAMP_UP.
  - RAMP_UP: each S2 load does gain += RAMP_STEP, capped at 256. When gain reaches 256, move to UNMUTED. i_mute=1 moves to RAMP_DOWN from the current gain.
  - The gain update occurs in the same cycle S2 loads. S2 uses the pre-update gain.
  - State transitions driven by i_mute are evaluated every cycle. Gain steps occur only on S2 loads, so with no samples flowing the gain freezes.
- Clip hold:
  - A counter reloads to CLIP_HOLD on any clipped output and decrements on each non-clipped o_dac_valid.
  - o_clip = (counter != 0).
  - A clip occurring while the counter is nonzero retriggers the hold.

## Timing
- Latency: i_sample_valid in cycle N gives o_dac_valid and a new o_dac_out in cycle N+3.
- Fully pipelined: back-to-back strobes (valid every cycle) are accepted with no stalls.
- There is no ready/backpressure signal.
- i_shift is captured with the sample. Changing it between strobes affects only later samples.
- Reset values:
  - o_dac_out = 2^(OUT_WIDTH-1) (midscale).
  - o_dac_valid, o_clip and o_muted = 0.
  - gain = 256, state = UNMUTED.
  - Pipeline valids and the clip counter are cleared.
- Reset mid-ramp or mid-pipeline drops all in-flight samples; no o_dac_valid is produced for them.
- Reset has priority over every other input in the same cycle.
- Zero input with gain 0 or with full shift outputs midscale exactly. Negative values floor, so -1 >>> n stays -1, giving 2^(OUT_WIDTH-1)-1.

## Configuration
- DAC_DITHER_EN: when defined, adds rectangular dither in S1.
  - A 16-bit Galois LFSR (taps 0xB400, reset seed 0xACE1) advances once per accepted sample.
  - S1 adds (lfsr & ((1<<shift)-1)) to the sample before the shift, using one guard bit. For shift=0 nothing is added.
  - The result is stochastic rounding instead of floor.
- When undefined: plain floor shift. The LFSR is absent and the output is bit-exact deterministic.

## Test plan
- Passthrough: shift=2, i_sample=24'sd4, i_mute=0 → o_dac_out=32769 exactly 3 cycles later, with o_dac_valid a single pulse. Next, i_sample=-4 → 32767.
- Saturation and hold: shift=0, i_sample=100000 → 65535 with o_clip=1; i_sample=-100000 → 0. Then CLIP_HOLD non-clipping samples → o_clip falls after the CLIP_HOLD-th output.
- Soft mute: RAMP_STEP=1, shift=0, constant i_sample=4096, i_mute raised:
  - Output k of the ramp (the first ramping output has gain 256, the next 255, and so on) equals 32768 + floor(4096·g/256).
  - o_muted rises when gain reaches 0 and the output is 32768.
  - Lowering i_mute ramps back up to 36864.
- Ramp reversal: lower i_mute at gain=128 during RAMP_DOWN → gain climbs 129, 130, … with no jump, and o_muted never asserts.
- Reset mid-operation: reset during RAMP_DOWN with 3 samples in flight → no o_dac_valid afterwards, o_dac_out=32768, and the next sample passes at gain 256.
- Shift clamp plus back-to-back: i_shift=31 with i_sample=-2^23 on consecutive cycles → every output equals 32767 (-1 midscale-minus-one), one valid per cycle. Under DAC_DITHER_EN, check that the mean of 4096 outputs for input 2 at shift=2 is within 0.5±0.05 LSB above midscale.
